decoder_scan_sequencer: RTL
===========================

// Module: decoder_scan_sequencer
// PURPOSE
//  Upstream driver for the 2-to-4 enable decoder: steps a 2-bit select through
//  0..LAST_IDX with a programmable dwell per step and an optional blanking gap,
//  so the decoder's one-hot output scans rows/digits without overlap.
//  Single-pass or continuous operation. Drives decoder a[1:0]/en directly.
// PARAMETERS
//  DWELL_W    8  width of dwell input; active cycles per step = dwell+1
//  BLANK_CYC  2  cycles with en=0 between steps (0 = no blanking)
//  LAST_IDX   3  highest select value scanned (0..3), wraps to 0 after it
// PORTS
//  clk     in   1        rising-edge clock
//  rst_n   in   1        asynchronous active-low reset
//  start   in   1        begin scan; sampled only in IDLE
//  stop    in   1        abort scan; sampled in any state
//  mode    in   1        0 = continuous, 1 = single pass; latched on start
//  dwell   in   DWELL_W  active cycles per step minus 1; latched on start
//  sel     out  2        decoder select (feeds decoder a)
//  en      out  1        decoder enable; high only in ACTIVE
//  step    out  1        1-cycle pulse on first ACTIVE cycle of each index
//  busy    out  1        high in ACTIVE or BLANK
//  done    out  1        1-cycle pulse when single pass completes
// BEHAVIOUR
//  - All outputs registered. Reset (rst_n=0, async): state=IDLE, sel=0, en=0,
//    step=0, busy=0, done=0, internal counters=0.
//  - States: IDLE, ACTIVE, BLANK.
//  - IDLE: start=1 & stop=0 at edge k -> ACTIVE from edge k; sel=0, en=1,
//    step=1, busy=1 visible after edge k; mode/dwell latched at edge k.
//  - ACTIVE: en=1 for exactly dwell_q+1 cycles per index (dwell_q=0 -> 1 cycle).
//    At end of dwell:
//     * sel<LAST_IDX: BLANK_CYC>0 -> BLANK; else ACTIVE with sel+1, step=1.
//     * sel==LAST_IDX, mode_q=0: as above but next index is 0 (wrap).
//     * sel==LAST_IDX, mode_q=1: -> IDLE, en=0, busy=0, sel=0, done=1 one cycle.
//  - BLANK: en=0, sel holds previous index, busy=1 for exactly BLANK_CYC cycles,
//    then ACTIVE with next index (sel+1 or 0 on wrap), step=1.
//  - en and sel change on the same edge; sel never changes while en=1 within
//    a step, so the decoder sees no glitching index while enabled.
//  - stop=1 at any edge in ACTIVE/BLANK -> IDLE next cycle: en=0, busy=0,
//    sel=0, step=0, done=0 (abort never pulses done). stop+start in IDLE: stop
//    wins, remain IDLE.
//  - start while busy ignored; dwell/mode changes while busy ignored.
//  - Dwell counter width DWELL_W, counts 0..dwell_q, no overflow (max value
//    2^DWELL_W-1 gives 2^DWELL_W cycles). Blank counter sized clog2(BLANK_CYC+1).
//  - LAST_IDX=0: scans index 0 only; continuous mode repeats 0 with blanking,
//    step pulses each repeat.
//  - Reset mid-scan: immediate return to reset values, no done.
//  - Invariant: en=1 implies busy=1; done and step never both 1.
// TESTING
//  1 reset: rst_n=0 async mid-ACTIVE -> sel=0,en=0,busy=0 same cycle, no done.
//  2 single pass, dwell=2, BLANK_CYC=2: en high 3 cyc per sel 0,1,2,3, 2 cyc
//    en=0 gaps, 4 step pulses, done 1 cyc after last ACTIVE, busy low with it.
//  3 continuous, dwell=0, BLANK_CYC=0: sel 0,1,2,3,0,1.. each 1 cyc, en
//    stays 1, step every cycle, done never.
//  4 stop in BLANK after sel=1: next cycle IDLE, sel=0, en=0, no done; start
//    same cycle as stop in IDLE -> stays IDLE.
//  5 dwell=255 (DWELL_W=8): exactly 256 en cycles per index; change dwell
//    input mid-scan -> timing unchanged.
//  6 checker over all runs: en->busy, sel stable while en=1 within a step,
//    decoder one-hot output never has 2 bits set.

Source files
------------

// File: rtl/decoder_scan_sequencer_if.sv
// Control and decoder-drive signals between the scan sequencer and its host.
// The master modport is the host side; the slave modport is the sequencer side.
interface decoder_scan_sequencer_if #(
    parameter int unsigned DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               mode;
    logic [DWELL_W-1:0] dwell;
    logic [1:0]         sel;
    logic               en;
    logic               step;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, mode, dwell,
        input  sel, en, step, busy, done
    );

    modport slave (
        input  start, stop, mode, dwell,
        output sel, en, step, busy, done
    );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Steps a 2-bit decoder select through 0..LAST_IDX with a programmable dwell and an
// optional blanking gap, so the downstream 2-to-4 decoder never sees a changing index.
module decoder_scan_sequencer #(
    parameter int unsigned DWELL_W   = 8,
    parameter int unsigned BLANK_CYC = 2,
    parameter int unsigned LAST_IDX  = 3
) (
    input logic                      clk,
    input logic                      rst_n,
    decoder_scan_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StActive, StBlank} state_e;

    // Keep the blank counter at least 1 bit wide even when blanking is disabled.
    localparam int unsigned        BlankW    = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam bit                 HasBlank  = (BLANK_CYC > 0);
    localparam logic [1:0]         LastSel   = 2'(LAST_IDX);
    localparam logic [BlankW-1:0]  BlankLast = BlankW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    state_e              state_q, state_d;
    logic [1:0]          sel_q, sel_d;
    logic                en_q, en_d;
    logic                step_q, step_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                mode_q, mode_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic [BlankW-1:0]   blank_cnt_q, blank_cnt_d;
    logic [1:0]          next_idx;

    assign next_idx = (sel_q == LastSel) ? 2'd0 : sel_q + 2'd1;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        en_d        = en_q;
        step_d      = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        mode_d      = mode_q;
        dwell_d     = dwell_q;
        dwell_cnt_d = dwell_cnt_q;
        blank_cnt_d = blank_cnt_q;

        // Stop overrides everything, including a simultaneous start in idle.
        if (bus.stop) begin
            state_d     = StIdle;
            sel_d       = 2'd0;
            en_d        = 1'b0;
            busy_d      = 1'b0;
            dwell_cnt_d = '0;
            blank_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_d     = StActive;
                        sel_d       = 2'd0;
                        en_d        = 1'b1;
                        step_d      = 1'b1;
                        busy_d      = 1'b1;
                        mode_d      = bus.mode;
                        dwell_d     = bus.dwell;
                        dwell_cnt_d = '0;
                    end
                end
                StActive: begin
                    if (dwell_cnt_q == dwell_q) begin
                        dwell_cnt_d = '0;
                        if (sel_q == LastSel && mode_q) begin
                            state_d = StIdle;
                            sel_d   = 2'd0;
                            en_d    = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (HasBlank) begin
                            state_d     = StBlank;
                            en_d        = 1'b0;
                            blank_cnt_d = '0;
                        end else begin
                            sel_d  = next_idx;
                            step_d = 1'b1;
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + 1'b1;
                    end
                end
                StBlank: begin
                    if (blank_cnt_q == BlankLast) begin
                        state_d     = StActive;
                        sel_d       = next_idx;
                        en_d        = 1'b1;
                        step_d      = 1'b1;
                        blank_cnt_d = '0;
                    end else begin
                        blank_cnt_d = blank_cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sel_q       <= 2'd0;
            en_q        <= 1'b0;
            step_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mode_q      <= 1'b0;
            dwell_q     <= '0;
            dwell_cnt_q <= '0;
            blank_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            en_q        <= en_d;
            step_q      <= step_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mode_q      <= mode_d;
            dwell_q     <= dwell_d;
            dwell_cnt_q <= dwell_cnt_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    assign bus.sel  = sel_q;
    assign bus.en   = en_q;
    assign bus.step = step_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
